// File: rtl/rob_buffer.sv
// Circular reorder buffer: in-order allocation and retirement, out-of-order writeback.
// Optional same-cycle writeback-to-read-port bypass enabled by defining ROB_WB_BYPASS_EN.
module rob_buffer #(
    parameter int ROB_ENTRIES         = 8,
    parameter int ROB_ENTRY_WIDTH     = 3,
    parameter int ARCH_REG_INDEX_SIZE = 5,
    parameter int XLEN                = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           alloc_valid,
    input  logic [ARCH_REG_INDEX_SIZE-1:0] alloc_rd,
    input  logic                           alloc_writes_rd,
    output logic                           alloc_ready,
    output logic [ROB_ENTRY_WIDTH-1:0]     alloc_rob_id,
    input  logic                           wb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0]     wb_rob_id,
    input  logic [XLEN-1:0]                wb_value,
    input  logic                           wb_exception,
    input  logic [ROB_ENTRY_WIDTH-1:0]     rs1_rob_entry,
    input  logic [ROB_ENTRY_WIDTH-1:0]     rs2_rob_entry,
    output logic [XLEN-1:0]                rs1_value,
    output logic                           rs1_ready,
    output logic [XLEN-1:0]                rs2_value,
    output logic                           rs2_ready,
    output logic                           commit,
    output logic [ARCH_REG_INDEX_SIZE-1:0] commit_rd,
    output logic [ROB_ENTRY_WIDTH-1:0]     commit_rob_id,
    output logic [XLEN-1:0]                commit_value,
    output logic                           flush,
    output logic [ROB_ENTRY_WIDTH:0]       count
);

    localparam logic [ROB_ENTRY_WIDTH:0]   FULL_CNT = (ROB_ENTRY_WIDTH+1)'(ROB_ENTRIES);
    localparam logic [ROB_ENTRY_WIDTH:0]   CNT_ONE  = (ROB_ENTRY_WIDTH+1)'(1);
    localparam logic [ROB_ENTRY_WIDTH-1:0] ID_ONE   = ROB_ENTRY_WIDTH'(1);

    logic [ROB_ENTRIES-1:0]         valid_q, ready_q, exc_q, wrd_q;
    logic [ARCH_REG_INDEX_SIZE-1:0] rd_q    [ROB_ENTRIES];
    logic [XLEN-1:0]                value_q [ROB_ENTRIES];
    logic [ROB_ENTRY_WIDTH-1:0]     head_q, tail_q;
    logic [ROB_ENTRY_WIDTH:0]       count_q, count_d;

    logic retire, alloc_fire, wb_fire;
    logic byp1, byp2;

    assign retire     = valid_q[head_q] && ready_q[head_q];
    assign flush      = retire && exc_q[head_q];
    assign commit     = retire && !exc_q[head_q] && wrd_q[head_q];
    assign alloc_ready = (count_q != FULL_CNT) && !flush;
    assign alloc_fire = alloc_valid && alloc_ready;
    // Writebacks to squashed or unallocated entries are discarded.
    assign wb_fire    = wb_valid && valid_q[wb_rob_id] && !flush;

    assign alloc_rob_id  = tail_q;
    assign commit_rd     = rd_q[head_q];
    assign commit_rob_id = head_q;
    assign commit_value  = value_q[head_q];
    assign count         = count_q;

`ifdef ROB_WB_BYPASS_EN
    assign byp1 = wb_valid && !wb_exception && !flush && (wb_rob_id == rs1_rob_entry);
    assign byp2 = wb_valid && !wb_exception && !flush && (wb_rob_id == rs2_rob_entry);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_ready = valid_q[rs1_rob_entry] && (ready_q[rs1_rob_entry] || byp1);
    assign rs2_ready = valid_q[rs2_rob_entry] && (ready_q[rs2_rob_entry] || byp2);
    assign rs1_value = byp1 ? wb_value : value_q[rs1_rob_entry];
    assign rs2_value = byp2 ? wb_value : value_q[rs2_rob_entry];

    always_comb begin
        count_d = count_q;
        if (alloc_fire && !retire)
            count_d = count_q + CNT_ONE;
        else if (!alloc_fire && retire)
            count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ready_q <= '0;
            exc_q   <= '0;
            wrd_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (wb_fire) begin
                ready_q[wb_rob_id] <= 1'b1;
                exc_q[wb_rob_id]   <= wb_exception;
            end
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                exc_q[tail_q]   <= 1'b0;
                wrd_q[tail_q]   <= alloc_writes_rd;
                tail_q          <= tail_q + ID_ONE;
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + ID_ONE;
            end
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by the control bits above.
    always_ff @(posedge clk) begin
        if (alloc_fire)
            rd_q[tail_q] <= alloc_rd;
        if (wb_fire)
            value_q[wb_rob_id] <= wb_value;
    end

endmodule

// File: tb/tb_rob_buffer.sv
// Directed bench for rob_buffer; commit/flush events are checked by a scoreboard monitor.
module tb_rob_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid, alloc_writes_rd;
    logic [4:0]  alloc_rd;
    logic        alloc_ready;
    logic [2:0]  alloc_rob_id;
    logic        wb_valid, wb_exception;
    logic [2:0]  wb_rob_id;
    logic [31:0] wb_value;
    logic [2:0]  rs1_rob_entry, rs2_rob_entry;
    logic [31:0] rs1_value, rs2_value;
    logic        rs1_ready, rs2_ready;
    logic        commit, flush;
    logic [4:0]  commit_rd;
    logic [2:0]  commit_rob_id;
    logic [31:0] commit_value;
    logic [3:0]  count;

    typedef struct packed {
        logic        fl;
        logic [4:0]  rd;
        logic [2:0]  id;
        logic [31:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    rob_buffer dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_writes_rd(alloc_writes_rd),
        .alloc_ready(alloc_ready), .alloc_rob_id(alloc_rob_id),
        .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value), .wb_exception(wb_exception),
        .rs1_rob_entry(rs1_rob_entry), .rs2_rob_entry(rs2_rob_entry),
        .rs1_value(rs1_value), .rs1_ready(rs1_ready), .rs2_value(rs2_value), .rs2_ready(rs2_ready),
        .commit(commit), .commit_rd(commit_rd), .commit_rob_id(commit_rob_id),
        .commit_value(commit_value), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic fl, input logic [4:0] rd, input logic [2:0] id, input logic [31:0] v);
        ev_t e;
        e.fl = fl; e.rd = rd; e.id = id; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
    endtask

    // Scoreboard monitor: every commit or flush presented by the DUT must match the next expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && (commit === 1'b1 || flush === 1'b1)) begin
            ev_t act;
            ev_t exp;
            act = {flush, commit_rd, commit_rob_id, commit_value};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got fl=%0d rd=%0d id=%0d val=0x%0h, none expected",
                         act.fl, act.rd, act.id, act.val);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL retire_event: got fl=%0d rd=%0d id=%0d val=0x%0h expected fl=%0d rd=%0d id=%0d val=0x%0h",
                             act.fl, act.rd, act.id, act.val, exp.fl, exp.rd, exp.id, exp.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        alloc_valid = 0; alloc_writes_rd = 0; alloc_rd = 0;
        wb_valid = 0; wb_exception = 0; wb_rob_id = 0; wb_value = 0;
        rs1_rob_entry = 0; rs2_rob_entry = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_alloc_ready", 32'(alloc_ready), 1);
        chk("rst_alloc_id", 32'(alloc_rob_id), 0);
        chk("rst_commit", 32'(commit), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_rs1_ready", 32'(rs1_ready), 0);
        chk("rst_rs2_ready", 32'(rs2_ready), 0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Allocate rd 5,6,7
        alloc_valid = 1; alloc_writes_rd = 1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = 5'(5 + i);
            #1 chk("alloc_id", 32'(alloc_rob_id), i);
            tick();
        end
        alloc_valid = 0;
        #1 chk("count3", 32'(count), 3);
        chk("no_commit_alloc", 32'(commit), 0);

        // Out-of-order writeback 2,1,0
        wb_valid = 1; wb_exception = 0;
        wb_rob_id = 2; wb_value = 32'h22;
        #1 chk("no_commit_wb2", 32'(commit), 0);
        tick();
        wb_rob_id = 1; wb_value = 32'h33;
        #1 chk("no_commit_wb1", 32'(commit), 0);
        tick();
        wb_rob_id = 0; wb_value = 32'h11;
        #1 chk("no_commit_wb0", 32'(commit), 0);
        push(0, 5, 0, 32'h11);
        push(0, 6, 1, 32'h33);
        push(0, 7, 2, 32'h22);
        tick();
        wb_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("commit_run", 32'(commit), 1);
            tick();
        end
        #1 chk("commit_done", 32'(commit), 0);
        chk("count_empty", 32'(count), 0);

        // Fill and wrap-around
        reset_pulse();
        alloc_valid = 1; alloc_writes_rd = 1;
        for (int i = 0; i < 8; i++) begin
            alloc_rd = 5'(8 + i);
            #1 chk("fill_id", 32'(alloc_rob_id), i);
            tick();
        end
        alloc_rd = 20;
        #1 chk("full_count", 32'(count), 8);
        chk("full_not_ready", 32'(alloc_ready), 0);
        wb_valid = 1; wb_rob_id = 0; wb_value = 32'h100;
        push(0, 8, 0, 32'h100);
        tick();
        wb_valid = 0;
        #1 chk("full_retire_refuse", 32'(alloc_ready), 0);
        chk("full_retire_commit", 32'(commit), 1);
        tick();
        #1 chk("wrap_ready", 32'(alloc_ready), 1);
        chk("wrap_id", 32'(alloc_rob_id), 0);
        chk("wrap_count7", 32'(count), 7);
        tick();
        alloc_valid = 0;
        #1 chk("wrap_count8", 32'(count), 8);
        chk("wrap_head", 32'(commit_rob_id), 1);
        chk("wrap_full", 32'(alloc_ready), 0);

        // Exception flush
        reset_pulse();
        alloc_valid = 1; alloc_writes_rd = 1;
        for (int i = 0; i < 3; i++) begin
            alloc_rd = 5'(1 + i);
            tick();
        end
        alloc_valid = 0;
        wb_valid = 1; wb_exception = 0; wb_rob_id = 1; wb_value = 32'h55;
        tick();
        wb_rob_id = 2; wb_value = 32'h66;
        tick();
        wb_rob_id = 0; wb_value = 32'h77; wb_exception = 1;
        push(1, 1, 0, 32'h77);
        tick();
        wb_valid = 0; wb_exception = 0;
        alloc_valid = 1; alloc_rd = 9;
        #1 chk("flush_high", 32'(flush), 1);
        chk("flush_no_commit", 32'(commit), 0);
        chk("flush_no_alloc", 32'(alloc_ready), 0);
        tick();
        alloc_valid = 0;
        #1 chk("post_flush_count", 32'(count), 0);
        chk("post_flush_id", 32'(alloc_rob_id), 0);
        chk("post_flush_low", 32'(flush), 0);

        // Read port and bypass
        alloc_valid = 1; alloc_writes_rd = 1;
        for (int i = 0; i < 4; i++) begin
            alloc_rd = 5'(10 + i);
            tick();
        end
        alloc_valid = 0;
        rs1_rob_entry = 3; rs2_rob_entry = 0;
        wb_valid = 1; wb_rob_id = 3; wb_value = 32'hABCD;
        #1;
`ifdef ROB_WB_BYPASS_EN
        chk("byp_rs1_ready", 32'(rs1_ready), 1);
        chk("byp_rs1_value", rs1_value, 32'hABCD);
`else
        chk("nobyp_rs1_ready", 32'(rs1_ready), 0);
`endif
        chk("rs2_pending", 32'(rs2_ready), 0);
        tick();
        wb_valid = 0;
        #1 chk("rd_rs1_ready", 32'(rs1_ready), 1);
        chk("rd_rs1_value", rs1_value, 32'hABCD);

        // Async reset with five entries occupied
        alloc_valid = 1; alloc_rd = 14;
        tick();
        alloc_valid = 0;
        wb_valid = 1; wb_rob_id = 0; wb_value = 32'h1;
        push(0, 10, 0, 32'h1);
        tick();
        wb_valid = 0;
        #1 chk("pre_rst_count", 32'(count), 5);
        chk("pre_rst_commit", 32'(commit), 1);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("async_count", 32'(count), 0);
        chk("async_commit", 32'(commit), 0);
        chk("async_alloc_ready", 32'(alloc_ready), 1);
        #1 reset = 1'b1;
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
